// File: rtl/dram_cmd_timing_scheduler.sv
// Single-rank DDR3 command timing scheduler.
// Pops one read/write request at a time from the bank-command issue queue,
// tracks the single open row and issues PRE/ACT/RD/WR to the PHY command
// channel spaced to honour tRP, tRCD, tRAS, tCCD and write-to-precharge.
// Open-page policy: the row stays open while the queue is empty.
module dram_cmd_timing_scheduler #(
  parameter int unsigned T_RP      = 5,
  parameter int unsigned T_RCD     = 5,
  parameter int unsigned T_RAS     = 15,
  parameter int unsigned T_CCD     = 4,
  parameter int unsigned T_WTP     = 16,
  parameter int unsigned ROW_BITS  = 14,
  parameter int unsigned COL_BITS  = 10,
  parameter int unsigned BANK_BITS = 3
) (
  input  logic                 clk1,
  input  logic                 rst,
  input  logic                 init_done,
  input  logic                 issue_queue_empty,
  output logic                 issue_queue_ren,
  input  logic                 req_write,
  input  logic [BANK_BITS-1:0] req_bank,
  input  logic [ROW_BITS-1:0]  req_row,
  input  logic [COL_BITS-1:0]  req_col,
  output logic [2:0]           cmd_o,
  output logic [BANK_BITS-1:0] cmd_bank_o,
  output logic [ROW_BITS-1:0]  cmd_addr_o,
  output logic                 wdata_ren,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_RW
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4
  } cmd_t;

  localparam logic [4:0] CNT_SAT = 5'd31;

  state_t                state;
  logic                  open_valid;
  logic [BANK_BITS-1:0]  open_bank;
  logic [ROW_BITS-1:0]   open_row;
  logic [4:0]            ras_cnt;
  logic [4:0]            ccd_cnt;
  logic [4:0]            wtp_cnt;
  logic [4:0]            wait_cnt;
  logic                  row_hit;

  // Head entry targets the row that is currently open.
  always_comb begin
    row_hit = open_valid && (open_bank == req_bank) && (open_row == req_row);
  end

  assign busy = (state != S_IDLE);

  // Command FSM, spacing counters and registered command outputs.
  // Spacing counters are loaded with 1 on the issuing edge so that a value of
  // N means N edges have elapsed; a threshold check against T_x then yields a
  // spacing of exactly T_x edges. wait_cnt is loaded with T-2 because the
  // wait state exit and the following issue state consume the last two edges.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      open_valid      <= 1'b0;
      open_bank       <= '0;
      open_row        <= '0;
      ras_cnt         <= CNT_SAT;
      ccd_cnt         <= CNT_SAT;
      wtp_cnt         <= CNT_SAT;
      wait_cnt        <= '0;
      cmd_o           <= CMD_NOP;
      cmd_bank_o      <= '0;
      cmd_addr_o      <= '0;
      issue_queue_ren <= 1'b0;
      wdata_ren       <= 1'b0;
    end else begin
      cmd_o           <= CMD_NOP;
      cmd_bank_o      <= '0;
      cmd_addr_o      <= '0;
      issue_queue_ren <= 1'b0;
      wdata_ren       <= 1'b0;
      ras_cnt         <= (ras_cnt == CNT_SAT) ? ras_cnt : ras_cnt + 5'd1;
      ccd_cnt         <= (ccd_cnt == CNT_SAT) ? ccd_cnt : ccd_cnt + 5'd1;
      wtp_cnt         <= (wtp_cnt == CNT_SAT) ? wtp_cnt : wtp_cnt + 5'd1;

      unique case (state)
        S_IDLE: begin
          if (init_done && !issue_queue_empty) begin
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (row_hit) begin
            state <= S_RW;
          end else if (!open_valid) begin
            state <= S_ACT;
          end else begin
            state <= S_PRE;
          end
        end

        S_PRE: begin
          if ((ras_cnt >= 5'(T_RAS)) && (wtp_cnt >= 5'(T_WTP))) begin
            cmd_o      <= CMD_PRE;
            cmd_bank_o <= open_bank;
            open_valid <= 1'b0;
            wait_cnt   <= 5'(T_RP - 2);
            state      <= S_WAIT_RP;
          end
        end

        S_WAIT_RP: begin
          if (wait_cnt == '0) begin
            state <= S_ACT;
          end else begin
            wait_cnt <= wait_cnt - 5'd1;
          end
        end

        S_ACT: begin
          cmd_o      <= CMD_ACT;
          cmd_bank_o <= req_bank;
          cmd_addr_o <= req_row;
          open_valid <= 1'b1;
          open_bank  <= req_bank;
          open_row   <= req_row;
          ras_cnt    <= 5'd1;
          wait_cnt   <= 5'(T_RCD - 2);
          state      <= S_WAIT_RCD;
        end

        S_WAIT_RCD: begin
          if (wait_cnt == '0) begin
            state <= S_RW;
          end else begin
            wait_cnt <= wait_cnt - 5'd1;
          end
        end

        S_RW: begin
          if (ccd_cnt >= 5'(T_CCD)) begin
            cmd_o           <= req_write ? CMD_WR : CMD_RD;
            cmd_bank_o      <= req_bank;
            cmd_addr_o      <= ROW_BITS'(req_col);
            issue_queue_ren <= 1'b1;
            wdata_ren       <= req_write;
            ccd_cnt         <= 5'd1;
            if (req_write) begin
              wtp_cnt <= 5'd1;
            end
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cmd_timing_scheduler.sv
// Directed bench for dram_cmd_timing_scheduler. A small request queue model
// feeds the head entry and pops it on issue_queue_ren; expected command
// cycles are hand-computed from the queue push cycle.
module tb_dram_cmd_timing_scheduler;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        init_done;
  logic        issue_queue_empty;
  logic        issue_queue_ren;
  logic        req_write;
  logic [2:0]  req_bank;
  logic [13:0] req_row;
  logic [9:0]  req_col;
  logic [2:0]  cmd_o;
  logic [2:0]  cmd_bank_o;
  logic [13:0] cmd_addr_o;
  logic        wdata_ren;
  logic        busy;

  always #5 clk1 = ~clk1;

  dram_cmd_timing_scheduler #(
    .T_RP(5), .T_RCD(5), .T_RAS(15), .T_CCD(4), .T_WTP(16),
    .ROW_BITS(14), .COL_BITS(10), .BANK_BITS(3)
  ) dut (
    .clk1(clk1), .rst(rst), .init_done(init_done),
    .issue_queue_empty(issue_queue_empty), .issue_queue_ren(issue_queue_ren),
    .req_write(req_write), .req_bank(req_bank), .req_row(req_row),
    .req_col(req_col), .cmd_o(cmd_o), .cmd_bank_o(cmd_bank_o),
    .cmd_addr_o(cmd_addr_o), .wdata_ren(wdata_ren), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ren_cnt = 0;
  int wren_cnt = 0;

  logic        q_wr   [0:15];
  logic [2:0]  q_bank [0:15];
  logic [13:0] q_row  [0:15];
  logic [9:0]  q_col  [0:15];
  int q_n = 0;
  int q_hd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_head();
    if (q_hd < q_n) begin
      issue_queue_empty = 1'b0;
      req_write = q_wr[q_hd];
      req_bank  = q_bank[q_hd];
      req_row   = q_row[q_hd];
      req_col   = q_col[q_hd];
    end else begin
      issue_queue_empty = 1'b1;
      req_write = 1'b0;
      req_bank  = '0;
      req_row   = '0;
      req_col   = '0;
    end
  endtask

  task automatic push(input logic w, input logic [2:0] b, input logic [13:0] r, input logic [9:0] c);
    q_wr[q_n] = w; q_bank[q_n] = b; q_row[q_n] = r; q_col[q_n] = c;
    q_n++;
    drive_head();
  endtask

  // One clock: sample after the edge, check pop strobes track the command.
  task automatic tick();
    @(posedge clk1);
    cyc++;
    #1;
    chk("ren_vs_cmd", 32'(issue_queue_ren), 32'(cmd_o == 3'd2 || cmd_o == 3'd3));
    chk("wren_vs_cmd", 32'(wdata_ren), 32'(cmd_o == 3'd3));
    if (cmd_o == 3'd0) chk("nop_fields", 32'({cmd_bank_o, cmd_addr_o}), 32'd0);
    if (wdata_ren) wren_cnt++;
    if (issue_queue_ren) begin
      ren_cnt++;
      if (q_hd < q_n) q_hd++;
      drive_head();
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_cmd(input string tag, input int ecmd, input int ebank,
                            input int eaddr, input int ecyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (cmd_o != 3'd0) found = 1'b1;
    end
    chk({tag, "_found"}, 32'(found), 32'd1);
    chk({tag, "_cmd"}, 32'(cmd_o), 32'(ecmd));
    chk({tag, "_bank"}, 32'(cmd_bank_o), 32'(ebank));
    chk({tag, "_addr"}, 32'(cmd_addr_o), 32'(eaddr));
    chk({tag, "_cycle"}, 32'(cyc), 32'(ecyc));
  endtask

  initial begin
    int c, w, r0, wr0, viol;
    rst = 1'b1;
    init_done = 1'b0;
    drive_head();
    #3;
    chk("rst_cmd", 32'(cmd_o), 32'd0);
    chk("rst_bank", 32'(cmd_bank_o), 32'd0);
    chk("rst_addr", 32'(cmd_addr_o), 32'd0);
    chk("rst_ren", 32'(issue_queue_ren), 32'd0);
    chk("rst_wren", 32'(wdata_ren), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick_n(3);
    rst = 1'b0;
    init_done = 1'b1;
    tick_n(2);

    // Cold read: ACT at +3, RD at ACT+5
    c = cyc; r0 = ren_cnt; wr0 = wren_cnt;
    push(1'b0, 3'd2, 14'h0100, 10'h008);
    expect_cmd("cold_act", 1, 2, 'h100, c + 3);
    chk("cold_busy", 32'(busy), 32'd1);
    expect_cmd("cold_rd", 2, 2, 'h008, c + 8);
    chk("cold_ren_pulses", 32'(ren_cnt - r0), 32'd1);
    chk("cold_wren_pulses", 32'(wren_cnt - wr0), 32'd0);
    tick_n(10);

    // Row-hit write stream, then row miss (tWTP bound), then row miss (tRAS bound)
    c = cyc; r0 = ren_cnt; wr0 = wren_cnt;
    for (int i = 0; i < 4; i++) push(1'b1, 3'd2, 14'h0100, 10'(16 + i));
    push(1'b0, 3'd2, 14'h0200, 10'h020);
    push(1'b0, 3'd2, 14'h0300, 10'h030);
    for (int i = 0; i < 4; i++)
      expect_cmd($sformatf("hit_wr%0d", i), 3, 2, 16 + i, c + 3 + 4 * i);
    chk("hit_ren_pulses", 32'(ren_cnt - r0), 32'd4);
    chk("hit_wren_pulses", 32'(wren_cnt - wr0), 32'd4);
    w = c + 15;
    expect_cmd("miss_pre_wtp", 4, 2, 0, w + 16);
    expect_cmd("miss_act", 1, 2, 'h200, w + 21);
    expect_cmd("miss_rd", 2, 2, 'h020, w + 26);
    expect_cmd("miss_pre_ras", 4, 2, 0, w + 36);
    expect_cmd("miss2_act", 1, 2, 'h300, w + 41);
    expect_cmd("miss2_rd", 2, 2, 'h030, w + 46);

    // Empty queue: idle, row stays open, next hit goes straight to RD
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cmd_o != 3'd0 || busy) viol++;
    end
    chk("empty_idle_violations", 32'(viol), 32'd0);
    c = cyc;
    push(1'b0, 3'd2, 14'h0300, 10'h005);
    expect_cmd("open_page_rd", 2, 2, 'h005, c + 3);

    // Init gating after a fresh reset
    rst = 1'b1;
    init_done = 1'b0;
    q_hd = q_n;
    drive_head();
    tick_n(2);
    rst = 1'b0;
    tick();
    r0 = ren_cnt;
    push(1'b0, 3'd1, 14'h00AA, 10'h003);
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cmd_o != 3'd0 || issue_queue_ren || busy) viol++;
    end
    chk("init_gate_violations", 32'(viol), 32'd0);
    chk("init_gate_no_pop", 32'(ren_cnt - r0), 32'd0);
    init_done = 1'b1;
    c = cyc;
    expect_cmd("init_act", 1, 1, 'h0AA, c + 3);
    expect_cmd("init_rd", 2, 1, 'h003, c + 8);
    tick_n(10);

    // Reset two cycles after ACT while in WAIT_RCD
    c = cyc;
    push(1'b1, 3'd4, 14'h1234, 10'h3FF);
    expect_cmd("rstmid_pre", 4, 1, 0, c + 3);
    expect_cmd("rstmid_act", 1, 4, 'h1234, c + 8);
    tick_n(2);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    r0 = ren_cnt;
    rst = 1'b1;
    #1;
    chk("rstmid_async_busy", 32'(busy), 32'd0);
    chk("rstmid_async_cmd", 32'(cmd_o), 32'd0);
    chk("rstmid_async_ren", 32'(issue_queue_ren), 32'd0);
    tick_n(3);
    rst = 1'b0;
    chk("rstmid_no_pop", 32'(ren_cnt - r0), 32'd0);
    c = cyc;
    expect_cmd("rstmid_reissue_act", 1, 4, 'h1234, c + 3);
    expect_cmd("rstmid_reissue_wr", 3, 4, 'h3FF, c + 8);
    chk("rstmid_pop_after", 32'(ren_cnt - r0), 32'd1);
    tick_n(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_cmd_timing_scheduler.md
# dram_cmd_timing_scheduler

Single-rank DDR3 command timing scheduler between the bank-command issue queue and the PHY command channel. It pops one read/write request at a time, tracks the single open row, and issues PRE/ACT/RD/WR commands spaced to meet tRP, tRCD, tRAS, tCCD and write-to-precharge. Commands are held until the initialization FSM reports done. Write-data pop requests go to the write-data FIFO.

## Interface
- T_RP, 5: PRE to ACT, in cycles
- T_RCD, 5: ACT to RD/WR, in cycles
- T_RAS, 15: ACT to PRE, in cycles
- T_CCD, 4: RD/WR to next RD/WR, in cycles
- T_WTP, 16: WR to PRE, in cycles (WL+4+tWR)
- ROW_BITS, 14: row address width
- COL_BITS, 10: column address width
- BANK_BITS, 3: bank address width

Ports:
- clk1  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- init_done  in  1  initialization complete; no command before it is high
- issue_queue_empty  in  1  issue queue has no entry
- issue_queue_ren  out  1  pop strobe, one cycle, head consumed
- req_write  in  1  head entry: 1 = write, 0 = read
- req_bank  in  BANK_BITS  head entry bank
- req_row  in  ROW_BITS  head entry row
- req_col  in  COL_BITS  head entry column
- cmd_o  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE
- cmd_bank_o  out  BANK_BITS  bank for cmd_o
- cmd_addr_o  out  ROW_BITS  row for ACT, zero-extended column for RD/WR, 0 for NOP/PRE
- wdata_ren  out  1  pop one burst from write-data FIFO, coincident with WR
- busy  out  1  high when state is not IDLE

## Operation
- States: IDLE, DECODE, PRE, WAIT_RP, ACT, WAIT_RCD, RW.
- IDLE: if init_done and !issue_queue_empty, go to DECODE. Otherwise stay, cmd_o = NOP.
- DECODE: the head is sampled, not popped.
  - Row hit (open_valid, bank and row match): go to RW.
  - No row open: go to ACT.
  - Different row open: go to PRE.
- PRE: wait until ras_cnt >= T_RAS and wtp_cnt >= T_WTP. Then emit PRE for one cycle to the open bank, clear open_valid, load wait counter, and go to WAIT_RP.
- WAIT_RP: hold until T_RP cycles have elapsed since PRE, then go to ACT.
- ACT: emit ACT with req_bank/req_row, set open_valid and store the open bank and row, clear ras_cnt, go to WAIT_RCD.
- WAIT_RCD: hold until T_RCD cycles have elapsed since ACT, then go to RW.
- RW: wait until ccd_cnt >= T_CCD, then in one cycle:
  - emit RD or WR with req_col;
  - pulse issue_queue_ren;
  - pulse wdata_ren if the command is WR;
  - clear ccd_cnt, and clear wtp_cnt if WR;
  - go to IDLE.
- Open-page policy: the row stays open when the queue is empty. No auto-precharge and no refresh are generated by this block.
- ras_cnt, ccd_cnt and wtp_cnt are 5-bit counters that increment every cycle and saturate at 31. Parameters must be ≤ 31.
- Every command output is registered and is NOP/0 in every cycle except the issue cycle.
- init_done falling mid-operation is not supported. The FSM continues, and the requirement is only that it is stable after reset.

## Timing
- Reset values:
  - cmd_o = NOP, cmd_bank_o = 0, cmd_addr_o = 0;
  - issue_queue_ren = 0, wdata_ren = 0, busy = 0;
  - state IDLE, open_valid = 0;
  - ras_cnt, ccd_cnt and wtp_cnt = 31 (saturated, so the first command is not blocked).
- Spacing is measured between rising edges on which cmd_o is non-NOP:
  - ACT→RD/WR ≥ T_RCD;
  - PRE→ACT ≥ T_RP;
  - ACT→PRE ≥ T_RAS;
  - RD/WR→RD/WR ≥ T_CCD;
  - WR→PRE ≥ T_WTP.
- Latency from queue non-empty in IDLE to the command:
  - row hit with counters expired: command at cycle 3 (IDLE→DECODE→RW, command registered);
  - empty bank: ACT at cycle 3, RD/WR at ACT+T_RCD.
- issue_queue_ren and wdata_ren are high in exactly the cycle cmd_o is RD/WR. The head must stay stable from DECODE until that cycle.
- Asynchronous rst assertion at any time returns all outputs to reset values on the same edge as the assertion. Any in-flight command is dropped without popping.

## Test plan
- Cold read: init_done=1 after reset, one read at bank 2, row 0x0100, col 0x008 → ACT bank2/0x0100, RD 5 cycles later with cmd_addr_o=0x008, one ren pulse coincident with RD, wdata_ren=0.
- Row hit stream: four writes to bank 2, row 0x0100, queue continuously non-empty → WRs exactly 4 cycles apart, 4 ren and 4 wdata_ren pulses, no ACT/PRE.
- Row miss after write: WR at row 0x0100, then read at row 0x0200 → PRE ≥16 cycles after WR and ≥15 after ACT, ACT 5 cycles after PRE, RD 5 cycles after ACT.
- Init gating: init_done=0 with queue non-empty for 50 cycles → cmd_o=NOP and ren=0 throughout; after init_done rises, ACT within 3 cycles.
- Empty queue: after one read, empty for 100 cycles → cmd_o=NOP and busy=0, row stays open, so the next hit issues RD with no ACT.
- Reset mid-WAIT_RCD: assert rst 2 cycles after ACT → outputs at reset values immediately, no ren pulse; after release, the same request is reissued starting with ACT.
